// File: rtl/mini_prog_sequencer_pkg.sv
// Shared definitions for the mini CPU instruction interface: opcodes, NOP encoding,
// instruction field layout and the sequencer state encoding.
package mini_prog_sequencer_pkg;

  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_I   = 2'b01;
  localparam logic [1:0] OP_L   = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  localparam logic [15:0] NOP_INSTR = 16'h0002;

  localparam int OPC_LSB  = 0;
  localparam int OPC_MSB  = 1;
  localparam int RFLD_LSB = 2;
  localparam int RFLD_MSB = 7;
  localparam int IMM_LSB  = 8;
  localparam int IMM_MSB  = 15;

  typedef struct packed {
    logic [IMM_MSB-IMM_LSB:0]   imm;
    logic [RFLD_MSB-RFLD_LSB:0] rfld;
    logic [OPC_MSB-OPC_LSB:0]   opc;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  function automatic logic is_out(input instr_t i);
    return i.opc == OP_OUT;
  endfunction

endpackage

// File: rtl/mini_result_fifo.sv
// Result FIFO: 1-cycle push-to-visible latency, head shown combinationally on pop_data.
// Push when full is accepted only together with a pop; pop when empty is ignored.
module mini_result_fifo #(
  parameter int WIDTH  = 8,
  parameter int RDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(RDEPTH):0]   count
);

  localparam int AW = $clog2(RDEPTH);

  logic [WIDTH-1:0] mem [RDEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_eff;
  logic             pop_eff;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(RDEPTH));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_eff) wptr <= wptr + AW'(1);
      if (pop_eff)  rptr <= rptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff && !clear) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/mini_prog_sequencer.sv
// Host-side program loader/issuer for the mini CPU: one instruction per cycle, first issue 1 cycle after run.
// Output instructions stall in place while the result FIFO is full and not being popped.
module mini_prog_sequencer
  import mini_prog_sequencer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int RDEPTH = 4,
  parameter int WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          host_wdata,
  input  logic                      host_wvalid,
  output logic                      host_wready,
  input  logic                      host_run,
  input  logic                      host_clear,
  output logic [WIDTH-1:0]          host_rdata,
  output logic                      host_rvalid,
  input  logic                      host_rready,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DEPTH):0]    prog_len,
  output logic [15:0]               cpu_instr,
  input  logic [WIDTH-1:0]          cpu_result
);

  localparam int PW  = $clog2(DEPTH);
  localparam int PLW = PW + 1;
  localparam int CW  = $clog2(RDEPTH) + 1;

  seq_state_t       state_q, state_d;
  logic [15:0]      mem [DEPTH];
  logic [PLW-1:0]   prog_len_q;
  logic [PW-1:0]    pc_q;
  logic             byte_phase_q;
  logic [WIDTH-1:0] low_q;
  instr_t           instr_q;

  logic             clear_ok, run_ok, wr_fire;
  logic             cur_out, pop, push_ok, stall, push, last;
  logic [WIDTH-1:0] res_data;
  logic             res_full, res_empty;
  logic [CW-1:0]    res_count;

  assign host_wready = (state_q != ST_RUN) && (prog_len_q < PLW'(DEPTH));
  assign clear_ok    = host_clear && (state_q != ST_RUN);
  assign wr_fire     = host_wvalid && host_wready && !clear_ok;
  assign run_ok      = host_run && (state_q != ST_RUN) && !clear_ok &&
                       (prog_len_q != '0) && !byte_phase_q;

  assign cur_out = is_out(instr_q);
  assign pop     = host_rvalid && host_rready;
  assign push_ok = !res_full || pop;
  assign stall   = cur_out && !push_ok;
  assign push    = (state_q == ST_RUN) && cur_out && push_ok;
  assign last    = (PLW'(pc_q) == prog_len_q - PLW'(1));

  assign prog_len    = prog_len_q;
  assign cpu_instr   = instr_q;
  assign host_rvalid = (res_count != '0);
  assign host_rdata  = res_empty ? '0 : res_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (clear_ok)    state_d = ST_IDLE;
        else if (run_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall && last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_len_q   <= '0;
      byte_phase_q <= 1'b0;
      low_q        <= '0;
      pc_q         <= '0;
      instr_q      <= NOP_INSTR;
    end else if (clear_ok) begin
      prog_len_q   <= '0;
      byte_phase_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        byte_phase_q <= !byte_phase_q;
        if (!byte_phase_q) low_q      <= host_wdata;
        else               prog_len_q <= prog_len_q + PLW'(1);
      end
      if (run_ok) begin
        pc_q    <= '0;
        instr_q <= mem[0];
      end else if ((state_q == ST_RUN) && !stall) begin
        if (last) begin
          instr_q <= NOP_INSTR;
        end else begin
          pc_q    <= pc_q + PW'(1);
          instr_q <= mem[pc_q + PW'(1)];
        end
      end
    end
  end

  // Word store: the odd byte completes the word, low byte was latched on the even one.
  always_ff @(posedge clk) begin
    if (wr_fire && byte_phase_q) mem[prog_len_q[PW-1:0]] <= {host_wdata, low_q};
  end

  mini_result_fifo #(
    .WIDTH (WIDTH),
    .RDEPTH(RDEPTH)
  ) u_result_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear_ok),
    .push     (push),
    .push_data(cpu_result),
    .pop      (pop),
    .pop_data (res_data),
    .full     (res_full),
    .empty    (res_empty),
    .count    (res_count)
  );

endmodule
